// File: rtl/alu_pkg.sv
// Shared ALU types and sizing for the ROR sequencer and its datapath.
// Latency: none (types/constants only). Backpressure: not applicable.
package alu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int WIDTH    = 32;
   localparam int AMT_W    = 5;
   localparam int STEP_MAX = 15;

endpackage

// File: rtl/ror_seq_ctrl_ror.sv
// Combinational rotate-right by 0..15 (one pass of the sequencer).
// Latency: 0 cycles. Backpressure: none, purely combinational.
module ror_seq_ctrl_ror #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] din,
   input  logic [3:0]       amt,
   output logic [WIDTH-1:0] dout
);

   // Left shift by WIDTH yields zero, so amt==0 passes din through unchanged.
   assign dout = (din >> amt) | (din << (WIDTH - int'(amt)));

endmodule

// File: rtl/ror_seq_ctrl.sv
// Full-range rotate sequencer: chains ROR passes of at most STEP_MAX; ROR_SEQ_ROL_EN adds in_dir (rotate left).
// Latency: 1+ceil(amt/STEP_MAX) cycles accept-to-out_valid. Backpressure: result held in DONE until out_ready.
module ror_seq_ctrl #(
   parameter int WIDTH    = alu_pkg::WIDTH,
   parameter int AMT_W    = alu_pkg::AMT_W,
   parameter int STEP_MAX = alu_pkg::STEP_MAX
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
`ifdef ROR_SEQ_ROL_EN
   input  logic             in_dir,
`endif
   input  logic [WIDTH-1:0] in_data,
   input  logic [AMT_W-1:0] in_amt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             busy,
   output logic [2:0]       pass_cnt
);

   import alu_pkg::*;

   localparam logic [AMT_W-1:0] STEP_LIM = AMT_W'(STEP_MAX);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] data_reg;
   logic [WIDTH-1:0] ror_out;
   logic [AMT_W-1:0] rem;
   logic [AMT_W-1:0] rem_left;
   logic [AMT_W-1:0] amt_eff;
   logic [3:0]       step;
   logic             accept;

   // A left rotate by n is a right rotate by (WIDTH-n) mod WIDTH; truncation does the mod.
   always_comb begin
      amt_eff = in_amt;
`ifdef ROR_SEQ_ROL_EN
      if (in_dir) begin
         amt_eff = AMT_W'(WIDTH - int'(in_amt));
      end
`endif
   end

   always_comb begin
      step     = (rem > STEP_LIM) ? STEP_LIM[3:0] : rem[3:0];
      rem_left = rem - AMT_W'(step);
   end

   ror_seq_ctrl_ror #(
      .WIDTH (WIDTH)
   ) u_ror (
      .din  (data_reg),
      .amt  (step),
      .dout (ror_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      out_data  = '0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept    = 1'b1;
               state_nxt = (amt_eff == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (rem_left == '0) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_data  = data_reg;
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_reg <= '0;
         rem      <= '0;
         pass_cnt <= '0;
      end else if (accept) begin
         data_reg <= in_data;
         rem      <= amt_eff;
         pass_cnt <= '0;
      end else if (state == RUN) begin
         data_reg <= ror_out;
         rem      <= rem_left;
         pass_cnt <= pass_cnt + 3'd1;
      end
   end

endmodule

// File: tb/tb_ror_seq_ctrl.sv
// Bench for ror_seq_ctrl: vector table plus reset, backpressure and mid-operation reset sequences.
module tb_ror_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        in_dir;
   logic [31:0] in_data;
   logic [4:0]  in_amt;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        busy;
   logic [2:0]  pass_cnt;

   always #5 clk = ~clk;

   ror_seq_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
`ifdef ROR_SEQ_ROL_EN
      .in_dir    (in_dir),
`endif
      .in_data   (in_data),
      .in_amt    (in_amt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy),
      .pass_cnt  (pass_cnt)
   );

   typedef struct {
      logic [31:0] data;
      logic [4:0]  amt;
      logic        dir;
      logic [31:0] exp_data;
      logic [2:0]  exp_pass;
      int          exp_lat;
      int          hold;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      logic [2:0]  pass;
      int          lat;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic run_req(input vec_t v);
      int          lat;
      bit          seen;
      logic [31:0] held;
      exp_t        e;
      @(negedge clk);
      for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
      check("in_ready_idle", in_ready, 1);
      in_valid  = 1'b1;
      in_data   = v.data;
      in_amt    = v.amt;
      in_dir    = v.dir;
      out_ready = (v.hold == 0);
      @(posedge clk);
      sb.push_back('{v.exp_data, v.exp_pass, v.exp_lat});
      #1;
      in_valid = 1'b0;
      in_data  = $urandom;
      in_amt   = 5'($urandom);
      in_dir   = 1'($urandom);
      lat  = 0;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         lat++;
         if (out_valid) begin
            seen = 1;
            break;
         end
      end
      e = sb.pop_front();
      if (!seen) begin
         n_cmp++;
         n_fail++;
         $display("FAIL out_valid_timeout: got no out_valid, expected it after %0d cycles", e.lat);
         out_ready = 1'b1;
         return;
      end
      check("out_data", out_data, e.data);
      check("pass_cnt", 32'(pass_cnt), 32'(e.pass));
      check("latency", lat, e.lat);
      check("busy_done", busy, 1);
      check("in_ready_done", in_ready, 0);
      held = out_data;
      for (int i = 0; i < v.hold; i++) begin
         @(negedge clk);
         check("hold_valid", out_valid, 1);
         check("hold_data", out_data, held);
         check("hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("out_valid_after", out_valid, 0);
      check("in_ready_after", in_ready, 1);
      check("busy_after", busy, 0);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_dir    = 1'b0;
      in_data   = '0;
      in_amt    = '0;
      out_ready = 1'b1;

      vecs.push_back('{32'h0000_0002, 5'd3,  1'b0, 32'h4000_0000, 3'd1, 2, 0});
      vecs.push_back('{32'hDEAD_BEEF, 5'd0,  1'b0, 32'hDEAD_BEEF, 3'd0, 1, 0});
      vecs.push_back('{32'h0000_0001, 5'd31, 1'b0, 32'h0000_0002, 3'd3, 4, 0});
      vecs.push_back('{32'h0000_FFFF, 5'd16, 1'b0, 32'hFFFF_0000, 3'd2, 3, 0});
      vecs.push_back('{32'h8000_0001, 5'd15, 1'b0, 32'h0003_0000, 3'd1, 2, 0});
      vecs.push_back('{32'h1234_5678, 5'd30, 1'b0, 32'h48D1_59E0, 3'd2, 3, 0});
      vecs.push_back('{32'hF000_0000, 5'd1,  1'b0, 32'h7800_0000, 3'd1, 2, 0});
      vecs.push_back('{32'h0000_00F0, 5'd4,  1'b0, 32'h0000_000F, 3'd1, 2, 5});
`ifdef ROR_SEQ_ROL_EN
      vecs.push_back('{32'h0000_0001, 5'd4,  1'b1, 32'h0000_0010, 3'd2, 3, 0});
      vecs.push_back('{32'h1234_5678, 5'd0,  1'b1, 32'h1234_5678, 3'd0, 1, 0});
      vecs.push_back('{32'h8000_0000, 5'd1,  1'b1, 32'h0000_0001, 3'd3, 4, 0});
`endif

      #12;
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_data", out_data, 0);
      check("rst_pass_cnt", 32'(pass_cnt), 0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) run_req(vecs[i]);

      // Reset during the second pass of a 31-step rotate.
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = 32'h0000_0001;
      in_amt    = 5'd31;
      in_dir    = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      sb.push_back('{32'h0000_0002, 3'd3, 4});
      #1 in_valid = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_in_ready", in_ready, 1);
      check("midrst_pass_cnt", 32'(pass_cnt), 0);
      sb.delete();
      #3 rst_n = 1'b1;
      run_req('{32'd10, 5'd10, 1'b0, 32'h0280_0000, 3'd1, 2, 0});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
